// File: rtl/dmem_responder_if.sv
// Request/response bundle between the LSU and dmem_responder.
// The master drives a request and holds it until ready; the slave answers
// with a one-cycle done pulse carrying read data and an error flag.
interface dmem_responder_if #(
    parameter int RAM_WIDTH = 16,
    parameter int XLEN      = 32
);
    logic                 req;
    logic                 ready;
    logic [RAM_WIDTH-1:0] addr;
    logic [1:0]           width;
    logic                 w_rn;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      rdata;
    logic                 done;
    logic                 error;

    modport master (
        output req, addr, width, w_rn, wdata,
        input  ready, rdata, done, error
    );

    modport slave (
        input  req, addr, width, w_rn, wdata,
        output ready, rdata, done, error
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: byte-lane word array behind a req/ready handshake.
// Reads return raw bytes right-justified; the LSU does any extension.
// Optional build macro DMEM_MISALIGNED_EN: when defined, accesses that
// cross a word boundary run as a two-cycle SPLIT sequence; when undefined,
// crossing accesses are rejected with error and SPLIT is not built.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a request; aligned/non-crossing accesses finish here
//   SPLIT | second word of a crossing access (DMEM_MISALIGNED_EN only)
module dmem_responder #(
    parameter int DEPTH     = 1024,
    parameter int XLEN      = 32,
    parameter int RAM_WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RAM_WIDTH-1:0] DEPTH_A = RAM_WIDTH'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0
`ifdef DMEM_MISALIGNED_EN
        , SPLIT = 1'b1
`endif
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0] mem [DEPTH];

    logic            ready_q, done_q, error_q;
    logic [XLEN-1:0] rdata_q;

    logic [RAM_WIDTH-1:0] word_idx;
    logic [1:0]           offset;
    logic [3:0]           n_mask;
    logic [7:0]           lane_span;
    logic                 crossing;
    logic                 req_err;

    logic [IDX_W-1:0] mem_idx;
    logic [3:0]       mem_be;
    logic [XLEN-1:0]  mem_wdat;
    logic [XLEN-1:0]  mem_word;

    logic            done_next, error_next;
    logic [XLEN-1:0] rdata_next;

`ifdef DMEM_MISALIGNED_EN
    logic             load_split;
    logic [5:0]       hi_shift;
    logic [IDX_W-1:0] lat_idx;
    logic [3:0]       lat_lanes;
    logic [5:0]       lat_sh;
    logic             lat_wr;
    logic [XLEN-1:0]  lat_wdata;
    logic [XLEN-1:0]  lat_rd;
`endif

    // Expand a 4-bit byte-lane mask into a full-width bit mask.
    function automatic logic [XLEN-1:0] byte_mask(input logic [3:0] be);
        logic [XLEN-1:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

    assign word_idx = {2'b00, bus.addr[RAM_WIDTH-1:2]};
    assign offset   = bus.addr[1:0];

    // Width decode: lane mask for an aligned access of the requested size.
    always_comb begin
        case (bus.width)
            2'b00:   n_mask = 4'b0001;
            2'b01:   n_mask = 4'b0011;
            2'b10:   n_mask = 4'b1111;
            default: n_mask = 4'b0000;
        endcase
    end

    // Lanes spilling past bit 3 of the shifted mask belong to the next word.
    assign lane_span = {4'b0000, n_mask} << offset;
    assign crossing  = |lane_span[7:4];

`ifdef DMEM_MISALIGNED_EN
    assign req_err = (bus.width == 2'b11) || (word_idx >= DEPTH_A) ||
                     (crossing && ((word_idx + RAM_WIDTH'(1)) >= DEPTH_A));
    assign hi_shift = {3'(3'd4 - {1'b0, offset}), 3'b000};
`else
    assign req_err = (bus.width == 2'b11) || (word_idx >= DEPTH_A) || crossing;
`endif

    assign mem_word = mem[mem_idx];

    // Next state, memory port controls and response strobes.
    always_comb begin
        state_next = state;
        mem_idx    = '0;
        mem_be     = 4'b0000;
        mem_wdat   = '0;
        done_next  = 1'b0;
        error_next = 1'b0;
`ifdef DMEM_MISALIGNED_EN
        load_split = 1'b0;
`endif
        case (state)
            IDLE: begin
                // ready_q gates acceptance so nothing is taken while in reset.
                if (bus.req && ready_q) begin
                    done_next = 1'b1;
                    if (req_err) begin
                        error_next = 1'b1;
                    end else begin
                        mem_idx  = IDX_W'(word_idx);
                        mem_be   = bus.w_rn ? lane_span[3:0] : 4'b0000;
                        mem_wdat = bus.wdata << {offset, 3'b000};
`ifdef DMEM_MISALIGNED_EN
                        if (crossing) begin
                            done_next  = 1'b0;
                            load_split = 1'b1;
                            state_next = SPLIT;
                        end
`endif
                    end
                end
            end
`ifdef DMEM_MISALIGNED_EN
            SPLIT: begin
                mem_idx    = lat_idx;
                mem_be     = lat_wr ? lat_lanes : 4'b0000;
                mem_wdat   = lat_wdata;
                done_next  = 1'b1;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Read data: first part lands low, second-word bytes are stacked above it.
    always_comb begin
        rdata_next = '0;
        case (state)
            IDLE: begin
                if (!req_err) begin
                    rdata_next = (mem_word >> {offset, 3'b000}) & byte_mask(n_mask);
                end
            end
`ifdef DMEM_MISALIGNED_EN
            SPLIT: rdata_next = lat_rd | ((mem_word & byte_mask(lat_lanes)) << lat_sh);
`endif
            default: rdata_next = '0;
        endcase
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_be[k]) begin
                mem[mem_idx][8*k +: 8] <= mem_wdat[8*k +: 8];
            end
        end
    end

    // State register and registered handshake/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == IDLE);
            done_q  <= done_next;
            error_q <= error_next;
            if (done_next) begin
                rdata_q <= rdata_next;
            end
        end
    end

`ifdef DMEM_MISALIGNED_EN
    // Capture what the second half of a crossing access needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_idx   <= '0;
            lat_lanes <= 4'b0000;
            lat_sh    <= 6'd0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            lat_rd    <= '0;
        end else if (load_split) begin
            lat_idx   <= IDX_W'(word_idx + RAM_WIDTH'(1));
            lat_lanes <= lane_span[7:4];
            lat_sh    <= hi_shift;
            lat_wr    <= bus.w_rn;
            lat_wdata <= bus.wdata >> hi_shift;
            lat_rd    <= rdata_next;
        end
    end
`endif

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.error = error_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; expectations follow the build macro
// DMEM_MISALIGNED_EN (crossing accesses split vs. rejected).
module tb_dmem_responder;
`ifdef DMEM_MISALIGNED_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        ra;
    int          dcount;

    always #5 clk = ~clk;

    dmem_responder_if #(.RAM_WIDTH(16), .XLEN(32)) bus ();

    dmem_responder #(.DEPTH(1024), .XLEN(32), .RAM_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: present at a negedge, accept on the next posedge, then
    // count cycles from the accept edge until done is seen.
    task automatic xfer(input logic wr, input logic [15:0] a, input logic [1:0] w,
                        input logic [31:0] d, output logic [31:0] rdo, output logic ero,
                        output int lato, output logic rdy_after);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.w_rn  = wr;
        bus.addr  = a;
        bus.width = w;
        bus.wdata = d;
        check("ready_before_accept", {31'd0, bus.ready}, 32'd1);
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        rdy_after = bus.ready;
        lato = 1;
        while (!bus.done && lato < 8) begin
            @(negedge clk);
            lato++;
        end
        rdo = bus.rdata;
        ero = bus.error;
    endtask

    initial begin
        bus.req   = 1'b0;
        bus.w_rn  = 1'b0;
        bus.addr  = '0;
        bus.width = 2'b00;
        bus.wdata = '0;

        #12;
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", {31'd0, bus.ready}, 32'd1);

        xfer(1'b1, 16'h0010, 2'b10, 32'hDEADBEEF, rd, er, lat, ra);
        check("wr_word_lat", lat, 1);
        check("wr_word_err", {31'd0, er}, 32'd0);

        xfer(1'b0, 16'h0011, 2'b00, 32'h0, rd, er, lat, ra);
        check("rd_byte_data", rd, 32'h000000BE);
        check("rd_byte_lat", lat, 1);
        check("rd_byte_err", {31'd0, er}, 32'd0);

        xfer(1'b1, 16'h0014, 2'b10, 32'h00000000, rd, er, lat, ra);
        check("wr_zero_err", {31'd0, er}, 32'd0);

        xfer(1'b1, 16'h0013, 2'b01, 32'h0000CAFE, rd, er, lat, ra);
        check("cross_wr_lat", lat, MIS ? 2 : 1);
        check("cross_wr_err", {31'd0, er}, MIS ? 32'd0 : 32'd1);
        check("cross_wr_ready", {31'd0, ra}, MIS ? 32'd0 : 32'd1);

        xfer(1'b0, 16'h0010, 2'b10, 32'h0, rd, er, lat, ra);
        check("rd_w10_data", rd, MIS ? 32'hFEADBEEF : 32'hDEADBEEF);

        xfer(1'b0, 16'h0014, 2'b00, 32'h0, rd, er, lat, ra);
        check("rd_b14_data", rd, MIS ? 32'h000000CA : 32'h00000000);

        xfer(1'b0, 16'h0012, 2'b10, 32'h0, rd, er, lat, ra);
        check("cross_rd_data", rd, MIS ? 32'h00CAFEAD : 32'h00000000);
        check("cross_rd_err", {31'd0, er}, MIS ? 32'd0 : 32'd1);
        check("cross_rd_lat", lat, MIS ? 2 : 1);

        xfer(1'b1, 16'h0020, 2'b10, 32'h12345678, rd, er, lat, ra);
        check("wr_w20_err", {31'd0, er}, 32'd0);

        xfer(1'b1, 16'h0020, 2'b11, 32'hFFFFFFFF, rd, er, lat, ra);
        check("w11_err", {31'd0, er}, 32'd1);
        check("w11_data", rd, 32'd0);
        check("w11_lat", lat, 1);

        xfer(1'b0, 16'h1000, 2'b10, 32'h0, rd, er, lat, ra);
        check("oob_err", {31'd0, er}, 32'd1);
        check("oob_data", rd, 32'd0);

        xfer(1'b0, 16'h0FFE, 2'b10, 32'h0, rd, er, lat, ra);
        check("last_cross_err", {31'd0, er}, 32'd1);
        check("last_cross_lat", lat, 1);

        xfer(1'b0, 16'h0020, 2'b10, 32'h0, rd, er, lat, ra);
        check("w20_unchanged", rd, 32'h12345678);

        xfer(1'b0, 16'h0023, 2'b00, 32'h0, rd, er, lat, ra);
        check("byte_off3", rd, 32'h00000012);
        xfer(1'b0, 16'h0021, 2'b01, 32'h0, rd, er, lat, ra);
        check("half_off1", rd, 32'h00003456);
        check("half_off1_err", {31'd0, er}, 32'd0);

        // Back-to-back aligned word writes with req held high.
        @(negedge clk);
        bus.req   = 1'b1;
        bus.w_rn  = 1'b1;
        bus.width = 2'b10;
        bus.addr  = 16'h0000;
        bus.wdata = 32'h11111111;
        for (int k = 0; k < 4; k++) begin
            check("b2b_ready", {31'd0, bus.ready}, 32'd1);
            @(posedge clk);
            #1;
            if (k < 3) begin
                bus.addr  = 16'((k + 1) * 4);
                bus.wdata = 32'h11111111 * 32'(k + 2);
            end else begin
                bus.req = 1'b0;
            end
            @(negedge clk);
            check("b2b_done", {31'd0, bus.done}, 32'd1);
            check("b2b_err", {31'd0, bus.error}, 32'd0);
        end
        @(negedge clk);
        check("b2b_done_end", {31'd0, bus.done}, 32'd0);

        xfer(1'b0, 16'h0008, 2'b10, 32'h0, rd, er, lat, ra);
        check("b2b_rd8", rd, 32'h33333333);
        xfer(1'b0, 16'h000C, 2'b10, 32'h0, rd, er, lat, ra);
        check("b2b_rdC", rd, 32'h44444444);

        // Reset while a crossing write is in its second phase.
        xfer(1'b1, 16'h001C, 2'b10, 32'h00000000, rd, er, lat, ra);
        check("wr_1c_err", {31'd0, er}, 32'd0);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.w_rn  = 1'b1;
        bus.width = 2'b10;
        bus.addr  = 16'h001E;
        bus.wdata = 32'h11223344;
        check("split_rst_ready_pre", {31'd0, bus.ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check("split_rst_ready", {31'd0, bus.ready}, 32'd0);
        check("split_rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check("split_rst_done2", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("split_rst_no_done", dcount, 0);
        check("split_rst_ready_post", {31'd0, bus.ready}, 32'd1);

        xfer(1'b0, 16'h001E, 2'b01, 32'h0, rd, er, lat, ra);
        check("split_rst_half", rd, MIS ? 32'h00003344 : 32'h00000000);
        xfer(1'b0, 16'h0020, 2'b10, 32'h0, rd, er, lat, ra);
        check("split_rst_w20", rd, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
